// File: rtl/win3x3_pkg.sv
// Shared constants and state encoding for the 3x3 window strip controller.
package win3x3_pkg;
  localparam int IMG_W      = 256;
  localparam int STRIP_ROWS = 32;
  localparam int PAD_W      = IMG_W + 2;
  localparam int LOAD_DEPTH = PAD_W * (STRIP_ROWS + 2);
  localparam int NUM_WIN    = IMG_W * STRIP_ROWS;

  localparam int LCNT_W = $clog2(LOAD_DEPTH + 1);
  localparam int RCNT_W = $clog2(NUM_WIN);
  localparam int COL_W  = $clog2(IMG_W);
  localparam int ROW_W  = $clog2(STRIP_ROWS);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_LOAD, S_READ, S_DRAIN, S_DONE
  } state_t;
endpackage

// File: rtl/win3x3_coord_cnt.sv
// Row/column raster counter: column wraps into the next row, terminal flag on the last cell.
module win3x3_coord_cnt #(
  parameter int COLS  = 256,
  parameter int ROWS  = 32,
  parameter int COL_W = 8,
  parameter int ROW_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [ROW_W-1:0] row,
  output logic [COL_W-1:0] col,
  output logic             last
);
  logic col_end;
  assign col_end = (col == COL_W'(COLS - 1));
  assign last    = col_end && (row == ROW_W'(ROWS - 1));

  always_ff @(posedge clk) begin
    if (!rst_n || clr) begin
      row <= '0;
      col <= '0;
    end else if (en) begin
      if (col_end) begin
        col <= '0;
        row <= last ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end
endmodule

// File: rtl/win3x3_frame_ctrl.sv
// Strip sequencer for the padded 3x3 window buffer: clear, load one padded strip, issue window reads.
module win3x3_frame_ctrl
  import win3x3_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  input  logic [7:0]       in_pixel,
  output logic             in_ready,
  output logic             mem_rst_n,
  output logic             mem_wr,
  output logic [7:0]       mem_wdata,
  output logic             mem_rd,
  input  logic             out_ready,
  output logic             win_valid,
  output logic [ROW_W-1:0] win_row,
  output logic [COL_W-1:0] win_col,
  output logic             busy,
  output logic             done
);
  state_t            state;
  logic [LCNT_W-1:0] load_cnt;
  logic [RCNT_W-1:0] rd_cnt;
  logic [ROW_W-1:0]  iss_row;
  logic [COL_W-1:0]  iss_col;
  logic              iss_last;
  logic              in_load, in_read;

  assign in_load = (state == S_LOAD);
  assign in_read = (state == S_READ);

  // Strobes are gated by rst_n so an aborting reset cycle never touches the buffer.
  assign in_ready  = rst_n & in_load;
  assign mem_wr    = in_ready & in_valid;
  assign mem_wdata = in_load ? in_pixel : '0;
  assign mem_rd    = rst_n & in_read & out_ready;
  assign mem_rst_n = rst_n & (state != S_CLEAR);
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);

  win3x3_coord_cnt #(
    .COLS (IMG_W),
    .ROWS (STRIP_ROWS),
    .COL_W(COL_W),
    .ROW_W(ROW_W)
  ) u_iss (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state == S_CLEAR),
    .en   (mem_rd),
    .row  (iss_row),
    .col  (iss_col),
    .last (iss_last)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      load_cnt  <= '0;
      rd_cnt    <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      // Buffer returns the window one cycle after the read; tag it with the issue coordinates.
      win_valid <= mem_rd;
      if (mem_rd) begin
        win_row <= iss_row;
        win_col <= iss_col;
      end
      case (state)
        S_IDLE:  if (start) state <= S_CLEAR;
        S_CLEAR: begin
          load_cnt <= '0;
          rd_cnt   <= '0;
          state    <= S_LOAD;
        end
        S_LOAD: if (mem_wr) begin
          load_cnt <= load_cnt + 1'b1;
          if (load_cnt == LCNT_W'(LOAD_DEPTH - 1)) state <= S_READ;
        end
        S_READ: if (mem_rd) begin
          rd_cnt <= rd_cnt + 1'b1;
          // Flat count and raster counter must agree on the final window.
          if (rd_cnt == RCNT_W'(NUM_WIN - 1) && iss_last) state <= S_DRAIN;
        end
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule
